// File: rtl/param_memory_if.sv
// Bus bundle for param_memory: read port, write/load port and load-pointer
// control. The master side (client) drives requests; the slave side (the
// memory) returns read data, pointer state and write status pulses.
interface param_memory_if #(
   parameter int DATA_W = 15,
   parameter int ADDR_W = 5
);
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;

   logic              wr_en;
   logic              wr_mode;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic              ptr_incr;
   logic              ptr_clr;
   logic [ADDR_W-1:0] wr_ptr;
   logic              wr_done;
   logic              full;
   logic              wr_err;

   modport master (
      output rd_en, rd_addr, wr_en, wr_mode, wr_addr, wr_data, ptr_incr, ptr_clr,
      input  rd_data, rd_valid, wr_ptr, wr_done, full, wr_err
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_mode, wr_addr, wr_data, ptr_incr, ptr_clr,
      output rd_data, rd_valid, wr_ptr, wr_done, full, wr_err
   );
endinterface

// File: rtl/param_memory.sv
// Single-port-write / single-port-read parameter memory with a load pointer.
// Writes are either sequential loads at the (possibly just advanced) load
// pointer or random writes at an explicit address. The read port is
// registered; on a same-address collision it returns either the new data
// (BYPASS=1) or the old content (BYPASS=0). With WRAP=0 the load pointer
// saturates and a sticky full flag blocks further loads until ptr_clr.
module param_memory #(
   parameter int                DATA_W     = 15,
   parameter int                ADDR_W     = 5,
   parameter int                WRAP       = 0,
   parameter int                BYPASS     = 1,
   parameter logic [DATA_W-1:0] INIT_WORD0 = 15'h7D00
) (
   input logic           clk,
   input logic           rst,
   param_memory_if.slave bus
);
   localparam int                DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] LAST      = '1;
   localparam bit                SATURATE  = (WRAP == 0);
   localparam bit                BYPASS_EN = (BYPASS != 0);

   // Storage is never reset; only word 0 has a non-zero power-up value.
   logic [DATA_W-1:0] mem [DEPTH] = '{0: INIT_WORD0, default: '0};

   logic [ADDR_W-1:0] ptr_reg, ptr_next;
   logic              full_reg, full_next, full_eff;
   logic              load_req, load_reject, load_commit, wr_commit;
   logic [ADDR_W-1:0] wr_addr_eff;
   logic [DATA_W-1:0] rd_data_reg, rd_data_next;
   logic              rd_valid_reg, wr_done_reg, wr_err_reg;

   // Load-pointer update: clear beats increment; increment wraps or saturates at the top.
   always_comb begin
      ptr_next = ptr_reg;
      if (bus.ptr_clr) begin
         ptr_next = '0;
      end else if (bus.ptr_incr) begin
         if (ptr_reg != LAST) begin
            ptr_next = ptr_reg + 1'b1;
         end else if (!SATURATE) begin
            ptr_next = '0;
         end else begin
            ptr_next = LAST;
         end
      end
   end

   // Write qualification; ptr_clr is applied before the load so it also lifts a pending full.
   always_comb begin
      full_eff     = full_reg & ~bus.ptr_clr;
      load_req     = bus.wr_en & ~bus.wr_mode;
      load_reject  = load_req & SATURATE & full_eff;
      load_commit  = load_req & ~load_reject;
      wr_commit    = load_commit | (bus.wr_en & bus.wr_mode);
      wr_addr_eff  = bus.wr_mode ? bus.wr_addr : ptr_next;
      full_next    = full_eff | (load_commit & SATURATE & (ptr_next == LAST));
      rd_data_next = mem[bus.rd_addr];
      if (BYPASS_EN && wr_commit && (wr_addr_eff == bus.rd_addr)) begin
         rd_data_next = bus.wr_data;
      end
   end

   // Memory array write; a write landing on an edge while rst is high is discarded.
   always_ff @(posedge clk) begin
      if (wr_commit && !rst) begin
         mem[wr_addr_eff] <= bus.wr_data;
      end
   end

   // Control state, status pulses and registered read data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_reg      <= '0;
         full_reg     <= 1'b0;
         wr_done_reg  <= 1'b0;
         wr_err_reg   <= 1'b0;
         rd_valid_reg <= 1'b0;
         rd_data_reg  <= '0;
      end else begin
         ptr_reg      <= ptr_next;
         full_reg     <= full_next;
         wr_done_reg  <= wr_commit;
         wr_err_reg   <= load_reject;
         rd_valid_reg <= bus.rd_en;
         if (bus.rd_en) begin
            rd_data_reg <= rd_data_next;
         end
      end
   end

   assign bus.wr_ptr   = ptr_reg;
   assign bus.full     = full_reg;
   assign bus.wr_done  = wr_done_reg;
   assign bus.wr_err   = wr_err_reg;
   assign bus.rd_valid = rd_valid_reg;
   assign bus.rd_data  = rd_data_reg;
endmodule

// File: tb/tb_param_memory.sv
// Bench for param_memory: instance a uses defaults (saturating pointer,
// write-first collisions); instance b uses WRAP=1, BYPASS=0. Reads are
// checked through per-instance scoreboard queues filled when a read is
// issued and drained by a monitor one edge later.
module tb_param_memory;
   localparam int DATA_W = 15;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   param_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_a ();
   param_memory_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_b ();

   param_memory u_a (.clk(clk), .rst(rst), .bus(bus_a));
   param_memory #(.WRAP(1), .BYPASS(0)) u_b (.clk(clk), .rst(rst), .bus(bus_b));

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] model_a [DEPTH];
   logic [DATA_W-1:0] model_b [DEPTH];
   logic [DATA_W-1:0] exp_a [$];
   logic [DATA_W-1:0] exp_b [$];

   // Scoreboard monitor: a read issued at an edge is checked 1 time unit later.
   always @(posedge clk) begin : mon
      logic              ra, rb, rs;
      logic [DATA_W-1:0] e;
      ra = bus_a.rd_en;
      rb = bus_b.rd_en;
      rs = rst;
      #1;
      if (!rs) begin
         checks++;
         if (ra) begin
            if (exp_a.size() == 0) begin
               errors++;
               $display("FAIL sb_a: read observed with empty expectation queue");
            end else begin
               e = exp_a.pop_front();
               $display("read a: valid=%0b data=%h expected=%h", bus_a.rd_valid, bus_a.rd_data, e);
               if (bus_a.rd_valid !== 1'b1 || bus_a.rd_data !== e) begin
                  errors++;
                  $display("FAIL sb_a: got valid=%0b data=%h, want valid=1 data=%h",
                           bus_a.rd_valid, bus_a.rd_data, e);
               end
            end
         end else if (bus_a.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_a_idle: got %0b want 0", bus_a.rd_valid);
         end
         checks++;
         if (rb) begin
            if (exp_b.size() == 0) begin
               errors++;
               $display("FAIL sb_b: read observed with empty expectation queue");
            end else begin
               e = exp_b.pop_front();
               $display("read b: valid=%0b data=%h expected=%h", bus_b.rd_valid, bus_b.rd_data, e);
               if (bus_b.rd_valid !== 1'b1 || bus_b.rd_data !== e) begin
                  errors++;
                  $display("FAIL sb_b: got valid=%0b data=%h, want valid=1 data=%h",
                           bus_b.rd_valid, bus_b.rd_data, e);
               end
            end
         end else if (bus_b.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_b_idle: got %0b want 0", bus_b.rd_valid);
         end
      end
   end

   task automatic idle_all();
      bus_a.rd_en = 0; bus_a.rd_addr = '0; bus_a.wr_en = 0; bus_a.wr_mode = 0;
      bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.ptr_incr = 0; bus_a.ptr_clr = 0;
      bus_b.rd_en = 0; bus_b.rd_addr = '0; bus_b.wr_en = 0; bus_b.wr_mode = 0;
      bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.ptr_incr = 0; bus_b.ptr_clr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_all();
      step();
      step();
      checks++;
      if ({bus_a.rd_data, bus_a.rd_valid, bus_a.wr_ptr, bus_a.wr_done, bus_a.full, bus_a.wr_err} !== '0) begin
         errors++;
         $display("FAIL reset_a: rd_data=%h rd_valid=%0b wr_ptr=%0d wr_done=%0b full=%0b wr_err=%0b, want all 0",
                  bus_a.rd_data, bus_a.rd_valid, bus_a.wr_ptr, bus_a.wr_done, bus_a.full, bus_a.wr_err);
      end
      checks++;
      if ({bus_b.rd_data, bus_b.rd_valid, bus_b.wr_ptr, bus_b.wr_done, bus_b.full, bus_b.wr_err} !== '0) begin
         errors++;
         $display("FAIL reset_b: outputs not all zero in reset");
      end
      rst = 1'b0;
      step();
   endtask

   task automatic test_init_read();
      bus_a.rd_en = 1; bus_a.rd_addr = 5'd5; exp_a.push_back(model_a[5]);
      step();
      bus_a.rd_addr = 5'd0; exp_a.push_back(model_a[0]);
      step();
      bus_a.rd_en = 0;
      step();
      step();
      checks++;
      if (bus_a.rd_data !== 15'h7D00) begin
         errors++;
         $display("FAIL rd_data_hold: got %h want 7d00", bus_a.rd_data);
      end
   endtask

   task automatic test_seq_load();
      bus_a.wr_en = 1; bus_a.wr_mode = 0; bus_a.ptr_incr = 1;
      for (int i = 1; i <= 3; i++) begin
         bus_a.wr_data = DATA_W'(16'h0010 + i);
         model_a[i] = DATA_W'(16'h0010 + i);
         step();
         $display("load a: word %0d data=%h wr_ptr=%0d wr_done=%0b", i, bus_a.wr_data, bus_a.wr_ptr, bus_a.wr_done);
         checks++;
         if (bus_a.wr_done !== 1'b1 || bus_a.wr_ptr !== ADDR_W'(i)) begin
            errors++;
            $display("FAIL seq_load_%0d: wr_done=%0b wr_ptr=%0d, want 1 and %0d", i, bus_a.wr_done, bus_a.wr_ptr, i);
         end
      end
      idle_all();
      step();
      checks++;
      if (bus_a.wr_done !== 1'b0 || bus_a.wr_ptr !== 5'd3) begin
         errors++;
         $display("FAIL seq_load_end: wr_done=%0b wr_ptr=%0d, want 0 and 3", bus_a.wr_done, bus_a.wr_ptr);
      end
   endtask

   task automatic test_back_to_back();
      bus_a.rd_en = 1;
      for (int i = 3; i >= 0; i--) begin
         bus_a.rd_addr = ADDR_W'(i);
         exp_a.push_back(model_a[i]);
         step();
      end
      idle_all();
      step();
   endtask

   task automatic test_fill_full();
      bus_a.ptr_clr = 1;
      step();
      bus_a.ptr_clr = 0;
      checks++;
      if (bus_a.wr_ptr !== 5'd0 || bus_a.full !== 1'b0) begin
         errors++;
         $display("FAIL fill_clr: wr_ptr=%0d full=%0b, want 0 0", bus_a.wr_ptr, bus_a.full);
      end
      bus_a.wr_en = 1; bus_a.wr_mode = 0;
      for (int i = 0; i < DEPTH; i++) begin
         bus_a.ptr_incr = (i != 0);
         bus_a.wr_data = DATA_W'(16'h0100 + i);
         model_a[i] = DATA_W'(16'h0100 + i);
         step();
         checks++;
         if (bus_a.wr_done !== 1'b1 || bus_a.wr_ptr !== ADDR_W'(i)) begin
            errors++;
            $display("FAIL fill_%0d: wr_done=%0b wr_ptr=%0d, want 1 and %0d", i, bus_a.wr_done, bus_a.wr_ptr, i);
         end
         if (i == DEPTH - 2) begin
            checks++;
            if (bus_a.full !== 1'b0) begin
               errors++;
               $display("FAIL full_early: full=%0b at ptr 30, want 0", bus_a.full);
            end
         end
      end
      checks++;
      if (bus_a.full !== 1'b1) begin
         errors++;
         $display("FAIL full_set: full=%0b, want 1", bus_a.full);
      end
      // Rejected load while full.
      bus_a.ptr_incr = 0; bus_a.wr_data = 15'h1234;
      step();
      $display("load a: rejected data=1234 wr_err=%0b wr_done=%0b", bus_a.wr_err, bus_a.wr_done);
      checks++;
      if (bus_a.wr_err !== 1'b1 || bus_a.wr_done !== 1'b0 || bus_a.full !== 1'b1) begin
         errors++;
         $display("FAIL full_reject: wr_err=%0b wr_done=%0b full=%0b, want 1 0 1", bus_a.wr_err, bus_a.wr_done, bus_a.full);
      end
      // Saturating increment at the top, plus word 31 still holds the old value.
      bus_a.wr_en = 0; bus_a.ptr_incr = 1;
      bus_a.rd_en = 1; bus_a.rd_addr = 5'd31; exp_a.push_back(model_a[31]);
      step();
      bus_a.rd_en = 0;
      checks++;
      if (bus_a.wr_ptr !== 5'd31 || bus_a.wr_err !== 1'b0) begin
         errors++;
         $display("FAIL saturate: wr_ptr=%0d wr_err=%0b, want 31 0", bus_a.wr_ptr, bus_a.wr_err);
      end
      // Random write ignores full and leaves the pointer alone.
      bus_a.ptr_incr = 0; bus_a.wr_en = 1; bus_a.wr_mode = 1;
      bus_a.wr_addr = 5'd31; bus_a.wr_data = 15'h0777; model_a[31] = 15'h0777;
      step();
      checks++;
      if (bus_a.wr_done !== 1'b1 || bus_a.wr_err !== 1'b0 || bus_a.wr_ptr !== 5'd31) begin
         errors++;
         $display("FAIL rand_when_full: wr_done=%0b wr_err=%0b wr_ptr=%0d, want 1 0 31",
                  bus_a.wr_done, bus_a.wr_err, bus_a.wr_ptr);
      end
      idle_all();
      bus_a.rd_en = 1; bus_a.rd_addr = 5'd31; exp_a.push_back(model_a[31]);
      step();
      bus_a.rd_en = 0; bus_a.ptr_clr = 1;
      step();
      bus_a.ptr_clr = 0;
      checks++;
      if (bus_a.full !== 1'b0 || bus_a.wr_ptr !== 5'd0) begin
         errors++;
         $display("FAIL full_clear: full=%0b wr_ptr=%0d, want 0 0", bus_a.full, bus_a.wr_ptr);
      end
   endtask

   task automatic test_wrap();
      bus_b.ptr_clr = 1;
      step();
      bus_b.ptr_clr = 0; bus_b.ptr_incr = 1;
      for (int i = 0; i < DEPTH - 2; i++) step();
      bus_b.wr_en = 1; bus_b.wr_mode = 0; bus_b.wr_data = 15'h0555; model_b[31] = 15'h0555;
      step();
      checks++;
      if (bus_b.wr_ptr !== 5'd31 || bus_b.wr_done !== 1'b1 || bus_b.full !== 1'b0) begin
         errors++;
         $display("FAIL wrap_top: wr_ptr=%0d wr_done=%0b full=%0b, want 31 1 0", bus_b.wr_ptr, bus_b.wr_done, bus_b.full);
      end
      bus_b.wr_en = 0;
      step();
      checks++;
      if (bus_b.wr_ptr !== 5'd0 || bus_b.full !== 1'b0) begin
         errors++;
         $display("FAIL wrap_zero: wr_ptr=%0d full=%0b, want 0 0", bus_b.wr_ptr, bus_b.full);
      end
      bus_b.ptr_incr = 0;
      bus_b.rd_en = 1; bus_b.rd_addr = 5'd31; exp_b.push_back(model_b[31]);
      step();
      idle_all();
      step();
   endtask

   task automatic test_collision();
      logic [ADDR_W-1:0] ptr_before;
      ptr_before = bus_a.wr_ptr;
      // Write-first instance.
      bus_a.wr_en = 1; bus_a.wr_mode = 1; bus_a.wr_addr = 5'd7; bus_a.wr_data = 15'h0ABC;
      bus_a.rd_en = 1; bus_a.rd_addr = 5'd7;
      model_a[7] = 15'h0ABC;
      exp_a.push_back(15'h0ABC);
      // Read-first instance.
      bus_b.wr_en = 1; bus_b.wr_mode = 1; bus_b.wr_addr = 5'd7; bus_b.wr_data = 15'h0ABC;
      bus_b.rd_en = 1; bus_b.rd_addr = 5'd7;
      exp_b.push_back(model_b[7]);
      model_b[7] = 15'h0ABC;
      step();
      checks++;
      if (bus_a.wr_done !== 1'b1 || bus_a.wr_ptr !== ptr_before) begin
         errors++;
         $display("FAIL rand_ptr: wr_done=%0b wr_ptr=%0d, want 1 and %0d", bus_a.wr_done, bus_a.wr_ptr, ptr_before);
      end
      idle_all();
      bus_b.rd_en = 1; bus_b.rd_addr = 5'd7; exp_b.push_back(model_b[7]);
      step();
      idle_all();
      step();
   endtask

   task automatic test_reset_mid_load();
      bus_a.ptr_clr = 1;
      step();
      bus_a.ptr_clr = 0; bus_a.wr_en = 1; bus_a.wr_mode = 0; bus_a.ptr_incr = 1;
      for (int i = 1; i <= 9; i++) begin
         bus_a.wr_data = DATA_W'(16'h0200 + i);
         model_a[i] = DATA_W'(16'h0200 + i);
         if (i == 9) begin
            bus_a.rd_en = 1; bus_a.rd_addr = 5'd1; exp_a.push_back(model_a[1]);
         end
         step();
      end
      bus_a.rd_en = 0;
      bus_a.wr_data = 15'h5EAD;
      checks++;
      if (bus_a.wr_ptr !== 5'd9 || bus_a.wr_done !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: wr_ptr=%0d wr_done=%0b, want 9 1", bus_a.wr_ptr, bus_a.wr_done);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus_a.rd_data, bus_a.rd_valid, bus_a.wr_ptr, bus_a.wr_done, bus_a.full, bus_a.wr_err} !== '0) begin
         errors++;
         $display("FAIL async_reset: rd_data=%h rd_valid=%0b wr_ptr=%0d wr_done=%0b, want all 0",
                  bus_a.rd_data, bus_a.rd_valid, bus_a.wr_ptr, bus_a.wr_done);
      end
      step();
      checks++;
      if (bus_a.wr_ptr !== 5'd0 || bus_a.wr_done !== 1'b0) begin
         errors++;
         $display("FAIL held_reset: wr_ptr=%0d wr_done=%0b, want 0 0", bus_a.wr_ptr, bus_a.wr_done);
      end
      idle_all();
      rst = 1'b0;
      step();
      bus_a.rd_en = 1;
      for (int i = 1; i <= 9; i++) begin
         bus_a.rd_addr = ADDR_W'(i);
         exp_a.push_back(model_a[i]);
         step();
      end
      idle_all();
      step();
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         model_a[i] = '0;
         model_b[i] = '0;
      end
      model_a[0] = 15'h7D00;
      model_b[0] = 15'h7D00;
      test_reset();
      test_init_read();
      test_seq_load();
      test_back_to_back();
      test_fill_full();
      test_wrap();
      test_collision();
      test_reset_mid_load();
      step();
      checks++;
      if (exp_a.size() != 0 || exp_b.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: pending a=%0d b=%0d, want 0 0", exp_a.size(), exp_b.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/param_memory.md
PARAM_MEMORY -- requirements
Module: param_memory

Interface
REQ-001 SHALL provide parameter DATA_W, default 15, word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL provide parameter WRAP, default 0; 1 = load pointer wraps DEPTH-1 -> 0, 0 = load pointer saturates.
REQ-004 SHALL provide parameter BYPASS, default 1; 1 = write-first on a same-address read/write collision, 0 = read-first.
REQ-005 SHALL provide parameter INIT_WORD0, default 15'h7D00, time-zero content of word 0; all other words are 0 at time zero.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 rd_en  input  1  read request.
REQ-009 rd_addr  input  ADDR_W  read address.
REQ-010 rd_data  output  DATA_W  registered read data.
REQ-011 rd_valid  output  1  one-cycle pulse; rd_data is valid.
REQ-012 wr_en  input  1  write request.
REQ-013 wr_mode  input  1  0 = sequential load at wr_ptr, 1 = random write at wr_addr.
REQ-014 wr_addr  input  ADDR_W  random-mode write address.
REQ-015 wr_data  input  DATA_W  write data.
REQ-016 ptr_incr  input  1  advance load pointer.
REQ-017 ptr_clr  input  1  synchronous load-pointer clear.
REQ-018 wr_ptr  output  ADDR_W  current load pointer.
REQ-019 wr_done  output  1  one-cycle pulse; a write was committed.
REQ-020 full  output  1  sticky; load write committed at DEPTH-1 (WRAP=0 only).
REQ-021 wr_err  output  1  one-cycle pulse; load write rejected.

Function
REQ-022 Read: rd_en=1 at edge N SHALL present mem[rd_addr] on rd_data and pulse rd_valid at N; rd_data SHALL hold its value while rd_en=0.
REQ-023 Pointer update order per edge SHALL be: ptr_clr (wins over ptr_incr) -> ptr_incr -> load write at the resulting pointer (ptr_incr+wr_en in one cycle writes to old wr_ptr+1).
REQ-024 ptr_incr at wr_ptr=DEPTH-1: WRAP=1 -> 0; WRAP=0 -> stays DEPTH-1.
REQ-025 Load write (wr_en=1, wr_mode=0) SHALL write wr_data to mem[effective pointer] and pulse wr_done, unless full=1 and WRAP=0, in which case the write SHALL be dropped, wr_err pulses, and wr_done stays 0.
REQ-026 A committed load write at pointer DEPTH-1 with WRAP=0 SHALL set full; only ptr_clr or rst SHALL clear full.
REQ-027 Random write (wr_en=1, wr_mode=1) SHALL write mem[wr_addr], pulse wr_done, and SHALL ignore full and leave wr_ptr unchanged except as set by ptr_clr/ptr_incr.
REQ-028 Collision: read and committed write to the same address on the same edge -> rd_data = wr_data if BYPASS=1, else the prior content.
REQ-029 wr_done, wr_err, rd_valid SHALL be single-cycle pulses, deasserted on any edge without a qualifying event.
REQ-030 All address arithmetic SHALL be modulo 2**ADDR_W; no out-of-range access is possible.

Reset
REQ-031 rst=1 SHALL immediately force rd_data=0, rd_valid=0, wr_ptr=0, wr_done=0, full=0, wr_err=0.
REQ-032 rst SHALL NOT alter memory contents; a write coinciding with rst SHALL be dropped.
REQ-033 After rst deasserts, the first edge SHALL operate normally.

Verification
REQ-034 Time zero, rd_en, rd_addr=0 -> next edge: rd_data=0x7D00, rd_valid=1; rd_addr=5 -> 0.
REQ-035 Defaults: wr_en+wr_mode=0 with data 0x0011..0x0013, ptr_incr held 1 -> words 1,2,3 written; wr_ptr=3; three wr_done pulses.
REQ-036 WRAP=0: fill 32 words via load -> full=1 after the write at 31; next load write of 0x1234 -> wr_err=1, word 31 unchanged; ptr_clr -> full=0, wr_ptr=0.
REQ-037 WRAP=1: wr_ptr=31, ptr_incr -> wr_ptr=0, full stays 0.
REQ-038 Random write 0x0ABC to addr 7 with simultaneous read of 7 -> BYPASS=1: rd_data=0x0ABC; BYPASS=0: old value, 0x0ABC on the following read.
REQ-039 Assert rst mid-load with wr_ptr=9 -> outputs zero asynchronously; earlier-written words readable after release.
